// File: rtl/bcd_countdown_display_if.sv
// Control and display bundle between the sequencing FSM and the BCD countdown display.
// The master drives Load/LoadValue/Enable/Blink; the slave returns the count, flags and segments.
interface bcd_countdown_display_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    Load;
    logic [4*NUM_DIGITS-1:0] LoadValue;
    logic                    Enable;
    logic                    Blink;
    logic [4*NUM_DIGITS-1:0] Count;
    logic                    Zero;
    logic                    Done;
    logic [7*NUM_DIGITS-1:0] Segments;

    modport master (
        output Load, LoadValue, Enable, Blink,
        input  Count, Zero, Done, Segments
    );

    modport slave (
        input  Load, LoadValue, Enable, Blink,
        output Count, Zero, Done, Segments
    );
endinterface

// File: rtl/bcd_countdown_display.sv
// Multi-digit BCD countdown timer with prescaled ticks, expiry flags and registered
// active-low 7-segment drive including leading-zero blanking and expiry blinking.
module bcd_countdown_display #(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int LEAD_BLANK = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    bcd_countdown_display_if.slave bus
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [SW-1:0] seg_q, seg_d;

    logic [DW-1:0] load_clamped;
    logic [DW-1:0] count_dec;
    logic [3:0]    load_digit;
    logic          borrow;
    logic [3:0]    show_digit;
    logic          higher_zero;
    logic          tick;
    logic          last_tick;
    logic          done;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0001100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign tick      = (state_q == RUN) && bus.Enable && (presc_q == TICK_LAST);
    assign last_tick = tick && (count_q == DW'(1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= '1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
        end
    end

    // Clamp of the load value and the rippling BCD borrow, e.g. 100 -> 099.
    always_comb begin
        load_clamped = '0;
        count_dec    = count_q;
        load_digit   = '0;
        borrow       = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            load_digit = bus.LoadValue[4*k +: 4];
            load_clamped[4*k +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    count_dec[4*k +: 4] = 4'd9;
                end else begin
                    count_dec[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.Load) begin
            state_d = (load_clamped != '0) ? RUN : EXPIRED;
        end else if (last_tick) begin
            state_d = EXPIRED;
        end
    end

    // Load discards a coincident tick; any entry into EXPIRED restarts the blink on the visible phase.
    always_comb begin
        count_d       = count_q;
        presc_d       = presc_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bus.Load) begin
            count_d       = load_clamped;
            presc_d       = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            if ((state_q == RUN) && bus.Enable) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                count_d = last_tick ? '0 : count_dec;
            end
            if (last_tick) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (state_q == EXPIRED) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // Done is combinational so it lands on the tick cycle itself, not on the following one.
    always_comb begin
        seg_d       = '1;
        show_digit  = '0;
        higher_zero = 1'b1;
        done        = last_tick && !bus.Load && !Reset;
        if (state_q != IDLE) begin
            for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
                show_digit  = count_q[4*k +: 4];
                higher_zero = higher_zero && (show_digit == 4'd0);
                if (!((LEAD_BLANK != 0) && (k > 0) && higher_zero)) begin
                    seg_d[7*k +: 7] = seg_decode(show_digit);
                end
            end
            if ((state_q == EXPIRED) && bus.Blink && blink_phase_q) begin
                seg_d = '1;
            end
        end
    end

    assign bus.Count    = count_q;
    assign bus.Zero     = (count_q == '0);
    assign bus.Done     = done;
    assign bus.Segments = seg_q;
endmodule

// File: tb/tb_bcd_countdown_display.sv
// Self-checking bench: a decimal-level model of the countdown is compared against the DUT on
// every falling edge, and directed scenarios pin the model with hand-computed literals.
module tb_bcd_countdown_display;
    localparam int ND = 2;
    localparam int TD = 4;
    localparam int BD = 3;

    logic Clock = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    always #5 Clock = ~Clock;

    bcd_countdown_display_if #(.NUM_DIGITS(ND)) bus ();

    bcd_countdown_display #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .BLINK_DIV (BD),
        .LEAD_BLANK(1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Model: mode 0 = idle, 1 = running, 2 = expired; value kept as a plain decimal integer.
    int          m_mode = 0;
    int          m_val = 0;
    int          m_run = 0;
    int          m_exp = 0;
    logic [13:0] m_seg = '1;
    bit          m_valid = 1'b0;

    function automatic int clamp_load(input logic [7:0] v);
        int hi;
        int lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seven(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] render(input int mode, input int val, input int exp_cycles,
                                           input logic blk);
        logic [13:0] s;
        if (mode == 0) return '1;
        if (mode == 2 && blk && ((exp_cycles / BD) % 2 == 1)) return '1;
        s[6:0]  = seven(val % 10);
        s[13:7] = (val / 10 == 0) ? 7'h7F : seven(val / 10);
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge Clock) begin
        int v;
        bit tk;
        tk = (m_mode == 1) && bus.Enable && (m_run % TD == TD - 1);
        m_seg <= render(m_mode, m_val, m_exp, bus.Blink);
        if (Reset) begin
            m_valid <= 1'b1;
            m_mode  <= 0;
            m_val   <= 0;
            m_run   <= 0;
            m_exp   <= 0;
            m_seg   <= '1;
        end else if (bus.Load) begin
            v = clamp_load(bus.LoadValue);
            m_val  <= v;
            m_run  <= 0;
            m_exp  <= 0;
            m_mode <= (v != 0) ? 1 : 2;
        end else if (m_mode == 1) begin
            if (bus.Enable) m_run <= m_run + 1;
            if (tk) begin
                m_val <= m_val - 1;
                if (m_val == 1) begin
                    m_mode <= 2;
                    m_exp  <= 0;
                end
            end
        end else if (m_mode == 2) begin
            m_exp <= m_exp + 1;
        end
    end

    always @(negedge Clock) begin
        logic exp_done;
        if (m_valid) begin
            exp_done = (m_mode == 1) && bus.Enable && (m_run % TD == TD - 1) && (m_val == 1)
                       && !bus.Load && !Reset;
            check_output("model count", 32'(bus.Count), 32'(to_bcd(m_val)));
            check_output("model zero", 32'(bus.Zero), 32'(m_val == 0));
            check_output("model done", 32'(bus.Done), 32'(exp_done));
            check_output("model segments", 32'(bus.Segments), 32'(m_seg));
            if (bus.Done === 1'b1) done_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] value, input logic en, input logic blk);
        bus.Load      = 1'b1;
        bus.LoadValue = value;
        bus.Enable    = en;
        bus.Blink     = blk;
        step(1);
        bus.Load = 1'b0;
    endtask

    task automatic wait_zero(input string name, input int budget);
        int n;
        n = 0;
        while (bus.Zero !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check_output({name, " reached zero"}, 32'(bus.Zero), 32'd1);
    endtask

    initial begin
        int d0;
        Reset         = 1'b1;
        bus.Load      = 1'b0;
        bus.LoadValue = '0;
        bus.Enable    = 1'b0;
        bus.Blink     = 1'b0;
        step(2);
        Reset = 1'b0;

        // Idle after reset: blank display, zero count.
        step(20);
        check_output("idle segments", 32'(bus.Segments), 32'h3FFF);
        check_output("idle count", 32'(bus.Count), 32'h00);
        check_output("idle zero", 32'(bus.Zero), 32'd1);
        check_output("idle done", 32'(bus.Done), 32'd0);

        // Count down from 12 with a single Done pulse.
        d0 = done_seen;
        apply_stimulus(8'h12, 1'b1, 1'b0);
        check_output("load 12 count", 32'(bus.Count), 32'h12);
        step(1);
        check_output("load 12 segments", 32'(bus.Segments), 32'h2792);
        wait_zero("run 12", 80);
        step(20);
        check_output("run 12 done pulses", 32'(done_seen - d0), 32'd1);

        // Pause is resumable: the prescaler keeps its value while Enable is low.
        apply_stimulus(8'h05, 1'b0, 1'b0);
        step(10);
        check_output("paused count", 32'(bus.Count), 32'h05);
        check_output("paused segments", 32'(bus.Segments), 32'h3FA4);
        bus.Enable = 1'b1;
        step(3);
        check_output("resume before tick", 32'(bus.Count), 32'h05);
        step(1);
        check_output("resume first tick", 32'(bus.Count), 32'h04);
        step(2);
        bus.Enable = 1'b0;
        step(10);
        bus.Enable = 1'b1;
        step(1);
        check_output("mid pause hold", 32'(bus.Count), 32'h04);
        step(1);
        check_output("mid pause resume", 32'(bus.Count), 32'h03);

        // Expiry blinking, then steady display once Blink drops.
        apply_stimulus(8'h03, 1'b1, 1'b1);
        wait_zero("blink run", 40);
        step(1);
        check_output("blink visible", 32'(bus.Segments), 32'h3F81);
        step(3);
        check_output("blink blank", 32'(bus.Segments), 32'h3FFF);
        step(3);
        check_output("blink visible again", 32'(bus.Segments), 32'h3F81);
        bus.Blink = 1'b0;
        step(3);
        check_output("blink off steady", 32'(bus.Segments), 32'h3F81);

        // Clamping and Load colliding with the final tick.
        apply_stimulus(8'hAF, 1'b1, 1'b0);
        check_output("clamp AF", 32'(bus.Count), 32'h99);
        apply_stimulus(8'h01, 1'b1, 1'b0);
        step(3);
        bus.Load      = 1'b1;
        bus.LoadValue = 8'h42;
        #1;
        check_output("load over tick done", 32'(bus.Done), 32'd0);
        step(1);
        bus.Load = 1'b0;
        check_output("load over tick count", 32'(bus.Count), 32'h42);
        step(3);
        check_output("load restarts prescaler", 32'(bus.Count), 32'h42);

        // Reset mid-count, then a zero load goes straight to expiry.
        apply_stimulus(8'h08, 1'b1, 1'b0);
        step(4);
        check_output("count 07", 32'(bus.Count), 32'h07);
        step(2);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        check_output("reset count", 32'(bus.Count), 32'h00);
        check_output("reset segments", 32'(bus.Segments), 32'h3FFF);
        check_output("reset zero", 32'(bus.Zero), 32'd1);
        apply_stimulus(8'h00, 1'b0, 1'b0);
        check_output("load 00 zero", 32'(bus.Zero), 32'd1);
        check_output("load 00 done", 32'(bus.Done), 32'd0);
        step(1);
        check_output("load 00 segments", 32'(bus.Segments), 32'h3F81);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
